// File: rtl/core_pkg.sv
// Shared definitions for the core front end: fetch FSM states and
// architectural constants used by the fetch stage.
package core_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int INSTR_BYTES  = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } fetch_state_t;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selection: hold, sequential (+4) or taken target.
// A taken branch to a non word-aligned target holds the PC and flags it.
module pc_next
    import core_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] pc,
    input  logic            instr_valid,
    input  logic [XLEN-1:0] instr_pc,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic [XLEN-1:0] next_pc,
    output logic            misalign_hit
);

    always_comb begin
        misalign_hit = br_taken && (br_target[1:0] != 2'b00);
        next_pc      = pc;
        // Until something has been fetched there is no PC to step from.
        if (!misalign_hit && instr_valid) begin
            next_pc = br_taken ? br_target : instr_pc + XLEN'(INSTR_BYTES);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// PC register and single-outstanding instruction fetch over a
// request/grant/response memory handshake.
module fetch_unit
    import core_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en_branch,
    input  logic            en_fetch,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    output logic            done,
    output logic            busy,
    output logic            misalign
);

    fetch_state_t    state, state_d;
    logic [XLEN-1:0] pc, pc_d;
    logic            pend_valid, pend_taken;
    logic [XLEN-1:0] pend_target;

    logic            completing, apply_upd;
    logic            sel_taken, base_valid;
    logic [XLEN-1:0] sel_target, base_pc, next_pc;
    logic            misalign_hit;

    assign completing = (state == WAIT) && imem_rvalid;
    assign imem_req   = (state == REQ);
    assign busy       = (state != IDLE);

    // On the completing cycle the update steps from the PC just fetched; a
    // branch arriving in that same cycle supersedes the pending one.
    always_comb begin
        apply_upd  = 1'b0;
        sel_taken  = br_taken;
        sel_target = br_target;
        base_pc    = instr_pc;
        base_valid = instr_valid;
        if (completing) begin
            base_pc    = imem_addr;
            base_valid = 1'b1;
            if (en_branch) begin
                apply_upd = 1'b1;
            end else if (pend_valid) begin
                apply_upd  = 1'b1;
                sel_taken  = pend_taken;
                sel_target = pend_target;
            end
        end else if (state == IDLE && en_branch) begin
            apply_upd = 1'b1;
        end
    end

    pc_next #(.XLEN(XLEN)) u_pc_next (
        .pc           (pc),
        .instr_valid  (base_valid),
        .instr_pc     (base_pc),
        .br_taken     (sel_taken),
        .br_target    (sel_target),
        .next_pc      (next_pc),
        .misalign_hit (misalign_hit)
    );

    assign pc_d = apply_upd ? next_pc : pc;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (en_fetch)    state_d = REQ;
            REQ:     if (imem_gnt)    state_d = WAIT;
            WAIT:    if (imem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_addr   <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            done        <= 1'b0;
            misalign    <= 1'b0;
            pend_valid  <= 1'b0;
            pend_taken  <= 1'b0;
            pend_target <= '0;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            done  <= completing;
            if (apply_upd && misalign_hit) begin
                misalign <= 1'b1;
            end
            if (state == IDLE && en_fetch) begin
                imem_addr <= pc_d;
            end
            if (completing) begin
                instr       <= imem_rdata;
                instr_pc    <= imem_addr;
                instr_valid <= 1'b1;
                pend_valid  <= 1'b0;
            end else if (state != IDLE && en_branch) begin
                pend_valid  <= 1'b1;
                pend_taken  <= br_taken;
                pend_target <= br_target;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against a transaction-level
// reference model of PC updates and fetch completions.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en_branch = 1'b0, en_fetch = 1'b0, br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic [31:0] instr, instr_pc;
    logic        instr_valid, done, busy, misalign;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int          m_state;
    logic [31:0] m_pc, m_addr, m_instr, m_instr_pc, m_pend_target;
    logic        m_valid, m_done, m_misalign, m_pend, m_pend_taken;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .en_branch   (en_branch),
        .en_fetch    (en_fetch),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .done        (done),
        .busy        (busy),
        .misalign    (misalign)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] redirect(input logic [31:0] cur_pc, input logic [31:0] base_pc,
                                             input logic base_valid, input logic taken,
                                             input logic [31:0] target, output logic bad);
        bad = taken && (target % 4 != 0);
        if (bad || !base_valid) return cur_pc;
        return taken ? target : base_pc + 32'd4;
    endfunction

    task automatic modelReset();
        m_state = 0;
        m_pc = 32'h0; m_addr = 32'h0; m_instr = '0; m_instr_pc = '0;
        m_valid = 0; m_done = 0; m_misalign = 0;
        m_pend = 0; m_pend_taken = 0; m_pend_target = '0;
    endtask

    task automatic checkAll();
        checkOutput("imem_req", {31'b0, imem_req}, {31'b0, m_state == 1});
        checkOutput("busy", {31'b0, busy}, {31'b0, m_state != 0});
        checkOutput("imem_addr", imem_addr, m_addr);
        checkOutput("done", {31'b0, done}, {31'b0, m_done});
        checkOutput("instr", instr, m_instr);
        checkOutput("instr_pc", instr_pc, m_instr_pc);
        checkOutput("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
        checkOutput("misalign", {31'b0, misalign}, {31'b0, m_misalign});
    endtask

    task automatic modelStep();
        logic [31:0] npc;
        logic        bad;
        bad = 0;
        npc = m_pc;
        if (m_state == 2 && imem_rvalid) begin
            m_instr = imem_rdata; m_instr_pc = m_addr; m_valid = 1; m_done = 1;
            if (en_branch) npc = redirect(m_pc, m_addr, 1'b1, br_taken, br_target, bad);
            else if (m_pend) npc = redirect(m_pc, m_addr, 1'b1, m_pend_taken, m_pend_target, bad);
            m_pend = 0;
            m_state = 0;
        end else begin
            m_done = 0;
            if (m_state == 0) begin
                if (en_branch) npc = redirect(m_pc, m_instr_pc, m_valid, br_taken, br_target, bad);
                if (en_fetch) begin
                    m_addr = npc;
                    m_state = 1;
                end
            end else begin
                if (en_branch) begin
                    m_pend = 1; m_pend_taken = br_taken; m_pend_target = br_target;
                end
                if (m_state == 1 && imem_gnt) m_state = 2;
            end
        end
        m_pc = npc;
        if (bad) m_misalign = 1;
    endtask

    task automatic applyStimulus(input logic b, input logic f, input logic t, input logic [31:0] tgt,
                                 input logic g, input logic rv, input logic [31:0] rd);
        @(negedge clk);
        en_branch = b; en_fetch = f; br_taken = t; br_target = tgt;
        imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
        @(posedge clk);
        modelStep();
        #1;
        checkAll();
    endtask

    task automatic doReset();
        @(negedge clk);
        en_branch = 0; en_fetch = 0; imem_gnt = 0; imem_rvalid = 0;
        reset = 1;
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        reset = 0;
    endtask

    task automatic fetchAt(input logic [31:0] exp_addr);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("fetch_addr", imem_addr, exp_addr);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, $urandom);
    endtask

    initial begin
        modelReset();
        doReset();

        // First fetch after reset uses the reset PC
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("first_addr", imem_addr, 32'h0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h0000_0013);
        checkOutput("first_done", {31'b0, done}, 32'h1);
        checkOutput("first_instr", instr, 32'h0000_0013);
        checkOutput("first_pc", instr_pc, 32'h0);

        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        fetchAt(32'h4);

        applyStimulus(1, 0, 1, 32'h100, 0, 0, 0);
        fetchAt(32'h100);

        applyStimulus(1, 0, 1, 32'h102, 0, 0, 0);
        checkOutput("misalign_set", {31'b0, misalign}, 32'h1);
        fetchAt(32'h100);

        // Long grant stall with a taken branch arriving mid-request
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(i == 2, 0, 1, 32'h200, 0, 0, 0);
            checkOutput("stall_req", {31'b0, imem_req}, 32'h1);
            checkOutput("stall_busy", {31'b0, busy}, 32'h1);
        end
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        fetchAt(32'h200);

        // PC wrap-around
        applyStimulus(1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        fetchAt(32'hFFFF_FFFC);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        fetchAt(32'h0);

        // Reset while waiting for the response
        doReset();
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        doReset();
        checkOutput("rst_req", {31'b0, imem_req}, 32'h0);
        checkOutput("rst_busy", {31'b0, busy}, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h1234_5678);
        checkOutput("rst_no_done", {31'b0, done}, 32'h0);
        checkOutput("rst_no_valid", {31'b0, instr_valid}, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            logic [31:0] tgt;
            tgt = {$urandom_range(0, 15) == 0 ? $urandom : ($urandom & 32'hFFFF_FFFC)};
            if ($urandom_range(0, 299) == 0) doReset();
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 1) == 1, tgt,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
